wbn2apb_bridge: RTL and testbench
=================================

WBN2APB_BRIDGE -- requirements
Module: wbn2apb_bridge

Interface
REQ-001 Parameter AW, default 32: address width.
REQ-002 Parameter DW, default 32: data width; a multiple of 8.
REQ-003 Parameter SW, default DW/8: byte-select width.
REQ-004 Parameter TO, default 16: ACCESS-phase timeout in cycles; 0 disables the timeout.
REQ-005 clk  in  1: the only clock; all state updates on its rising edge.
REQ-006 rst  in  1: reset, synchronous, active-high.
REQ-007 wbn_cyc, wbn_stb, wbn_we  in  1 each: Wishbone classic cycle, strobe and write enable.
REQ-008 wbn_adr  in  AW; wbn_sel  in  SW; wbn_dat_w  in  DW: address, byte select, write data.
REQ-009 wbn_dat_r  out  DW; wbn_ack, wbn_err, wbn_rty  out  1 each: read data and registered response.
REQ-010 apb_psel, apb_penable, apb_pwrite  out  1 each: APB select, enable and direction.
REQ-011 apb_paddr  out  AW; apb_pstrb  out  SW; apb_pwdata  out  DW: APB address, write strobes, write data.
REQ-012 apb_prdata  in  DW; apb_pready, apb_pslverr  in  1 each: APB slave response.

Function
REQ-013 The FSM SHALL have four states: IDLE, SETUP, ACCESS, RESP.
REQ-014 In IDLE, when wbn_cyc&wbn_stb is high, the bridge SHALL register adr/sel/dat_w/we into the APB outputs and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-015 In SETUP: psel=1, penable=0; the next state SHALL be ACCESS unconditionally.
REQ-016 In ACCESS: psel=1, penable=1; on pready=1 the bridge SHALL capture prdata (reads only) and pslverr, then go to RESP.
REQ-017 APB address, strobe, write data and pwrite SHALL stay stable from SETUP through the final ACCESS cycle.
REQ-018 apb_pstrb SHALL equal the captured wbn_sel for writes and SHALL be all-zero for reads.
REQ-019 In RESP, exactly one of wbn_ack or wbn_err SHALL be high for exactly one cycle: err if the captured pslverr is set or a timeout occurred, else ack; then the next state SHALL be IDLE.
REQ-020 Minimum latency SHALL be strobe sampled in cycle N -> ack/err in cycle N+3 (zero APB wait states).
REQ-021 A strobe still high in the IDLE cycle after RESP SHALL be treated as a new transfer; no transfer is ever issued twice.
REQ-022 When TO>0, a cycle counter SHALL clear on entry to ACCESS; when TO ACCESS cycles elapse without pready, the bridge SHALL deassert psel/penable and go to RESP with timeout flagged.
REQ-023 If pready arrives in the same cycle the timeout expires, pready SHALL win.
REQ-024 If wbn_cyc drops during SETUP or ACCESS, the APB transfer SHALL still complete (or time out), and RESP SHALL assert neither ack nor err.
REQ-025 wbn_dat_r SHALL hold the last captured read data; it is valid only when wbn_ack is high for a read.
REQ-026 wbn_rty SHALL be constant 0.

Reset
REQ-027 While rst=1 on a clock edge, the state SHALL go to IDLE, the timeout counter to 0, and all flags to 0.
REQ-028 After reset, psel, penable, pwrite, ack, err and rty SHALL be 0, and paddr, pstrb, pwdata and wbn_dat_r SHALL be all-zero.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no ack or err; APB signals SHALL drop in the following cycle.

Structure
REQ-030 Shared package wbn_apb_pkg SHALL hold the FSM state encoding (2-bit) and the response code constants (OK, SLVERR, TIMEOUT).
REQ-031 The timeout counter SHALL be a sub-module apb_timeout (parameter TO; inputs clr/en; output expired), generated only when TO>0.

Verification
REQ-032 Write adr=0x10, sel=4'b0011, dat=0xA5A5A5A5, pready tied 1 -> SETUP then ACCESS one cycle each; pstrb=0011; ack at N+3 for 1 cycle.
REQ-033 Read adr=0x20, pready after 3 wait cycles, prdata=0x12345678 -> ack at N+6; dat_r=0x12345678; pstrb=0.
REQ-034 Write, pslverr=1 with pready -> err for 1 cycle, ack stays 0.
REQ-035 TO=4, pready held 0 -> psel/penable drop after 4 ACCESS cycles; err for 1 cycle; next strobe accepted in IDLE.
REQ-036 Back-to-back: stb held high across two transfers -> two distinct APB transfers, two ack pulses, separated by one IDLE cycle.
REQ-037 rst asserted during ACCESS -> next cycle psel=penable=0 and state IDLE; no ack or err.

Source files
------------

// File: rtl/wbn_apb_pkg.sv
// Shared definitions for the Wishbone-classic to APB bridge.
// Holds the FSM state encoding and the response codes.
package wbn_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] RESP_OK      = 2'd0;
  localparam logic [1:0] RESP_SLVERR  = 2'd1;
  localparam logic [1:0] RESP_TIMEOUT = 2'd2;

endpackage

// File: rtl/apb_timeout.sv
// ACCESS-phase watchdog: counts enabled cycles since the last clear and
// flags the cycle in which the TO-th enabled cycle is reached.
module apb_timeout #(
  parameter int TO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TO + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)          r_cnt <= '0;
    else if (en && !expired) r_cnt <= r_cnt + 1'b1;
  end

  assign expired = en && (r_cnt == CW'(TO - 1));

endmodule

// File: rtl/wbn2apb_bridge.sv
// Wishbone classic slave to APB master bridge, one transfer at a time.
// Response is presented in RESP, one cycle after the APB transfer ends.
module wbn2apb_bridge
  import wbn_apb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int TO = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wbn_cyc,
  input  logic          wbn_stb,
  input  logic          wbn_we,
  input  logic [AW-1:0] wbn_adr,
  input  logic [SW-1:0] wbn_sel,
  input  logic [DW-1:0] wbn_dat_w,
  output logic [DW-1:0] wbn_dat_r,
  output logic          wbn_ack,
  output logic          wbn_err,
  output logic          wbn_rty,
  output logic          apb_psel,
  output logic          apb_penable,
  output logic          apb_pwrite,
  output logic [AW-1:0] apb_paddr,
  output logic [SW-1:0] apb_pstrb,
  output logic [DW-1:0] apb_pwdata,
  input  logic [DW-1:0] apb_prdata,
  input  logic          apb_pready,
  input  logic          apb_pslverr
);

  state_t        r_state, w_next;
  logic [AW-1:0] r_paddr;
  logic [SW-1:0] r_pstrb;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_dat_r;
  logic          r_pwrite;
  logic          r_abort;
  logic [1:0]    r_resp;
  logic          w_expired;
  logic          w_req;

  assign w_req = wbn_cyc && wbn_stb;

  generate
    if (TO > 0) begin : g_to
      apb_timeout #(.TO(TO)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (r_state == SETUP),
        .en      (r_state == ACCESS),
        .expired (w_expired)
      );
    end else begin : g_no_to
      assign w_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    wbn_ack     = 1'b0;
    wbn_err     = 1'b0;
    case (r_state)
      IDLE:   if (w_req) w_next = SETUP;
      SETUP: begin
        apb_psel = 1'b1;
        w_next   = ACCESS;
      end
      ACCESS: begin
        apb_psel    = 1'b1;
        apb_penable = 1'b1;
        if (apb_pready || w_expired) w_next = RESP;
      end
      RESP: begin
        // An abandoned Wishbone cycle gets no response at all
        wbn_ack = !r_abort && (r_resp == RESP_OK);
        wbn_err = !r_abort && (r_resp != RESP_OK);
        w_next  = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr  <= '0;
      r_pstrb  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_dat_r  <= '0;
      r_abort  <= 1'b0;
      r_resp   <= RESP_OK;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_paddr  <= wbn_adr;
        r_pwrite <= wbn_we;
        r_pwdata <= wbn_dat_w;
        r_pstrb  <= wbn_we ? wbn_sel : '0;
        r_abort  <= 1'b0;
        r_resp   <= RESP_OK;
      end
      if ((r_state == SETUP || r_state == ACCESS) && !wbn_cyc) r_abort <= 1'b1;
      // pready takes priority over a timeout expiring in the same cycle
      if (r_state == ACCESS) begin
        if (apb_pready) begin
          r_resp <= apb_pslverr ? RESP_SLVERR : RESP_OK;
          if (!r_pwrite) r_dat_r <= apb_prdata;
        end else if (w_expired) begin
          r_resp <= RESP_TIMEOUT;
        end
      end
    end
  end

  assign apb_paddr  = r_paddr;
  assign apb_pstrb  = r_pstrb;
  assign apb_pwdata = r_pwdata;
  assign apb_pwrite = r_pwrite;
  assign wbn_dat_r  = r_dat_r;
  assign wbn_rty    = 1'b0;

endmodule

// File: tb/tb_wbn2apb_bridge.sv
// Self-checking bench for wbn2apb_bridge (TO=4): vector table with a
// response scoreboard, plus back-to-back, cycle-drop and reset sequences.
module tb_wbn2apb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wbn_cyc = 1'b0, wbn_stb = 1'b0, wbn_we = 1'b0;
  logic [31:0] wbn_adr = '0, wbn_dat_w = '0, wbn_dat_r;
  logic [3:0]  wbn_sel = '0;
  logic        wbn_ack, wbn_err, wbn_rty;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic [3:0]  apb_pstrb;
  logic        apb_pready, apb_pslverr;

  int          cfg_waits = 0;
  logic        cfg_hang = 1'b0, cfg_slverr = 1'b0;
  logic [31:0] cfg_prdata = '0;
  int          scnt = 0;

  int checks = 0;
  int errors = 0;

  wbn2apb_bridge #(.AW(32), .DW(32), .SW(4), .TO(4)) dut (
    .clk(clk), .rst(rst),
    .wbn_cyc(wbn_cyc), .wbn_stb(wbn_stb), .wbn_we(wbn_we),
    .wbn_adr(wbn_adr), .wbn_sel(wbn_sel), .wbn_dat_w(wbn_dat_w),
    .wbn_dat_r(wbn_dat_r), .wbn_ack(wbn_ack), .wbn_err(wbn_err), .wbn_rty(wbn_rty),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pstrb(apb_pstrb), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  always #5 clk = ~clk;

  // APB slave model: ready after cfg_waits ACCESS cycles unless hung
  always @(posedge clk) begin
    if (apb_psel && apb_penable) scnt <= scnt + 1;
    else                         scnt <= 0;
  end
  assign apb_pready  = apb_psel && apb_penable && !cfg_hang && (scnt >= cfg_waits);
  assign apb_pslverr = cfg_slverr && apb_pready;
  assign apb_prdata  = cfg_prdata;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] wdat;
    int          waits;
    logic        hang;
    logic        slverr;
    logic [31:0] prdata;
    logic        exp_ack;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input vec_t v);
    exp_t e;
    int   lat;
    bit   done;
    cfg_waits  = v.waits;
    cfg_hang   = v.hang;
    cfg_slverr = v.slverr;
    cfg_prdata = v.prdata;
    wbn_cyc = 1'b1; wbn_stb = 1'b1; wbn_we = v.we;
    wbn_adr = v.adr; wbn_sel = v.sel; wbn_dat_w = v.wdat;
    e.ack = v.exp_ack; e.err = !v.exp_ack; e.rdata = v.prdata;
    e.chk_rdata = v.exp_ack && !v.we; e.lat = v.exp_lat;
    sb.push_back(e);
    lat = 0; done = 0;
    while (!done && lat < 30) begin
      step();
      lat++;
      if (lat == 1) begin
        chk("setup_phase", {apb_psel, apb_penable}, 2'b10);
        chk("paddr", apb_paddr, v.adr);
        chk("pwrite", apb_pwrite, v.we);
        chk("pstrb", apb_pstrb, v.we ? v.sel : 4'h0);
        chk("pwdata", apb_pwdata, v.wdat);
      end
      if (wbn_ack || wbn_err) begin
        done = 1;
        e = sb.pop_front();
        chk("resp_ack_err", {wbn_ack, wbn_err}, {e.ack, e.err});
        chk("latency", lat, e.lat);
        if (e.chk_rdata) chk("dat_r", wbn_dat_r, e.rdata);
        wbn_cyc = 1'b0; wbn_stb = 1'b0;
      end
    end
    if (!done) begin
      chk("response_timeout", 0, 1);
      void'(sb.pop_front());
      wbn_cyc = 1'b0; wbn_stb = 1'b0;
    end
    step();
    chk("one_cycle_pulse", {wbn_ack, wbn_err, apb_psel}, 3'b000);
  endtask

  initial begin
    int acks, setups, first, gap, resps, xfers;
    vecs[0] = '{1'b1, 32'h10, 4'b0011, 32'hA5A5A5A5, 0, 1'b0, 1'b0, 32'h0,        1'b1, 3};
    vecs[1] = '{1'b0, 32'h20, 4'b1111, 32'h0,        3, 1'b0, 1'b0, 32'h12345678, 1'b1, 6};
    vecs[2] = '{1'b1, 32'h24, 4'b1100, 32'h0BADF00D, 0, 1'b0, 1'b1, 32'h0,        1'b0, 3};
    vecs[3] = '{1'b0, 32'h28, 4'b1111, 32'h0,        1, 1'b0, 1'b1, 32'h55AA55AA, 1'b0, 4};
    vecs[4] = '{1'b1, 32'h2C, 4'b0001, 32'h11111111, 0, 1'b1, 1'b0, 32'h0,        1'b0, 6};
    vecs[5] = '{1'b0, 32'h30, 4'b1111, 32'h0,        0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b1, 3};
    vecs[6] = '{1'b1, 32'h34, 4'b1010, 32'hCAFEF00D, 3, 1'b0, 1'b0, 32'h0,        1'b1, 6};
    vecs[7] = '{1'b0, 32'h38, 4'b0110, 32'h0,        2, 1'b0, 1'b0, 32'h87654321, 1'b1, 5};

    repeat (3) step();
    chk("rst_apb_ctl", {apb_psel, apb_penable, apb_pwrite}, 3'b000);
    chk("rst_wb_resp", {wbn_ack, wbn_err, wbn_rty}, 3'b000);
    chk("rst_paddr_pstrb", {apb_paddr, apb_pstrb}, 36'h0);
    chk("rst_pwdata_datr", {apb_pwdata, wbn_dat_r}, 64'h0);
    rst = 1'b0;
    step();

    foreach (vecs[i]) run(vecs[i]);

    // Back-to-back: strobe held through two transfers
    cfg_waits = 0; cfg_hang = 1'b0; cfg_slverr = 1'b0;
    wbn_cyc = 1'b1; wbn_stb = 1'b1; wbn_we = 1'b1;
    wbn_adr = 32'h100; wbn_sel = 4'hF; wbn_dat_w = 32'h1;
    acks = 0; setups = 0; first = 0; gap = 0;
    for (int c = 1; c <= 20 && acks < 2; c++) begin
      step();
      if (apb_psel && !apb_penable) begin
        setups++;
        if (setups == 2) chk("b2b_second_paddr", apb_paddr, 32'h104);
      end
      if (wbn_ack) begin
        acks++;
        if (acks == 1) begin first = c; wbn_adr = 32'h104; end
        else gap = c - first;
      end
    end
    wbn_cyc = 1'b0; wbn_stb = 1'b0;
    repeat (4) begin
      step();
      if (apb_psel && !apb_penable) setups++;
    end
    chk("b2b_acks", acks, 2);
    chk("b2b_setups", setups, 2);
    chk("b2b_ack_gap", gap, 4);

    // Wishbone cycle dropped during SETUP: APB completes, no response
    cfg_waits = 2;
    wbn_cyc = 1'b1; wbn_stb = 1'b1; wbn_we = 1'b1; wbn_adr = 32'h40;
    step();
    wbn_cyc = 1'b0; wbn_stb = 1'b0;
    resps = 0; xfers = 0;
    repeat (10) begin
      if (wbn_ack || wbn_err) resps++;
      if (apb_psel && apb_penable && apb_pready) xfers++;
      step();
    end
    chk("cycdrop_no_resp", resps, 0);
    chk("cycdrop_apb_done", xfers, 1);

    // Reset during ACCESS abandons the transfer
    cfg_hang = 1'b1;
    wbn_cyc = 1'b1; wbn_stb = 1'b1; wbn_we = 1'b1; wbn_adr = 32'h50;
    step();
    step();
    chk("rst_mid_in_access", {apb_psel, apb_penable}, 2'b11);
    rst = 1'b1; wbn_cyc = 1'b0; wbn_stb = 1'b0;
    step();
    chk("rst_mid_apb_drop", {apb_psel, apb_penable}, 2'b00);
    rst = 1'b0;
    resps = 0;
    repeat (6) begin
      if (wbn_ack || wbn_err) resps++;
      step();
    end
    chk("rst_mid_no_resp", resps, 0);
    run(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
